// File: rtl/ex_shift_unit.sv
// ex_shift_unit: iterative 64-bit logical shifter (LSL/LSR) with done pulse.
// Define EX_SHIFT_MULTIBIT_EN to shift up to 8 bits per cycle.
module ex_shift_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic        ShiftDir,
  input  logic        ShiftToALUB,
  input  logic [5:0]  Shamt,
  input  logic [63:0] Din,
  output logic [63:0] Dout,
  output logic        done,
  output logic        busy,
  output logic        ShiftToALUBO
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  logic [5:0]  count;
  logic        dir;
  logic [5:0]  step;
  logic [5:0]  count_nxt;
  logic [63:0] shifted;

`ifdef EX_SHIFT_MULTIBIT_EN
  assign step = (count > 6'd8) ? 6'd8 : count;
`else
  assign step = 6'd1;
`endif

  always_comb begin
    count_nxt = count - step;
    shifted   = dir ? (Dout >> step) : (Dout << step);
  end

  // Stall depends on state only, never on inputs.
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      Dout         <= '0;
      count        <= '0;
      done         <= 1'b0;
      dir          <= 1'b0;
      ShiftToALUBO <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      Dout  <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            Dout         <= Din;
            dir          <= ShiftDir;
            ShiftToALUBO <= ShiftToALUB;
            count        <= Shamt;
            if (Shamt == 6'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          Dout  <= shifted;
          count <= count_nxt;
          if (count_nxt == 6'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_shift_unit.sv
// tb_ex_shift_unit: scoreboard bench for ex_shift_unit.
// Expected results queued at issue, checked by a done-driven monitor.
module tb_ex_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic        ShiftDir;
  logic        ShiftToALUB;
  logic [5:0]  Shamt;
  logic [63:0] Din;
  logic [63:0] Dout;
  logic        done;
  logic        busy;
  logic        ShiftToALUBO;

  ex_shift_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .ShiftDir     (ShiftDir),
    .ShiftToALUB  (ShiftToALUB),
    .Shamt        (Shamt),
    .Din          (Din),
    .Dout         (Dout),
    .done         (done),
    .busy         (busy),
    .ShiftToALUBO (ShiftToALUBO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dout;
    logic        tag;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

`ifdef EX_SHIFT_MULTIBIT_EN
  localparam logic [5:0] FL_SH = 6'd40;
`else
  localparam logic [5:0] FL_SH = 6'd10;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int lat(input int s);
`ifdef EX_SHIFT_MULTIBIT_EN
    return (s + 7) / 8 + 1;
`else
    return s + 1;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done=1 at cyc %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dout", Dout, e.dout);
        chk("tag", 64'(ShiftToALUBO), 64'(e.tag));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic run_op(input logic [63:0] din, input logic dir,
                        input logic [5:0] sh, input logic tag,
                        input logic [63:0] expd, input logic hold);
    int n;
    @(negedge clk);
    Din         = din;
    ShiftDir    = dir;
    Shamt       = sh;
    ShiftToALUB = tag;
    start       = 1'b1;
    q.push_back('{expd, tag, cyc + lat(int'(sh))});
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (!hold || done) start = 1'b0;
    end
    start = 1'b0;
    chk("busy_cycles", 64'(n), 64'(lat(int'(sh))));
    @(negedge clk);
    chk("dout_hold", Dout, expd);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    flush       = 1'b0;
    ShiftDir    = 1'b0;
    ShiftToALUB = 1'b0;
    Shamt       = '0;
    Din         = '0;
    repeat (2) @(negedge clk);
    chk("rst_dout", Dout, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tag", 64'(ShiftToALUBO), 64'd0);
    reset = 1'b1;

    run_op(64'h1, 1'b0, 6'd4, 1'b0, 64'h10, 1'b0);
    run_op(64'h8000_0000_0000_0000, 1'b1, 6'd63, 1'b0, 64'h1, 1'b0);
    run_op(64'hDEAD_BEEF, 1'b0, 6'd0, 1'b1, 64'hDEAD_BEEF, 1'b0);
    run_op(64'hF0, 1'b1, 6'd4, 1'b0, 64'hF, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd12, 1'b1,
           64'hFFFF_FFFF_FFFF_F000, 1'b0);
    run_op(64'h1234, 1'b0, 6'd9, 1'b0, 64'h24_6800, 1'b0);
    run_op(64'h1234, 1'b1, 6'd9, 1'b1, 64'h9, 1'b0);
    run_op(64'h1, 1'b0, 6'd63, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    // start held high across the whole op must not spawn a second op
    run_op(64'h3, 1'b0, 6'd3, 1'b1, 64'h18, 1'b1);

    // flush in the third SHIFT cycle with start still held
    @(negedge clk);
    Din      = 64'h1;
    ShiftDir = 1'b0;
    Shamt    = FL_SH;
    start    = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_dout", Dout, 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("flush_idle", 64'(busy), 64'd0);

    // flush beats start in IDLE
    run_op(64'hAA, 1'b0, 6'd1, 1'b0, 64'h154, 1'b0);
    @(negedge clk);
    Din   = 64'h5;
    Shamt = 6'd0;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("fs_busy", 64'(busy), 64'd0);
    chk("fs_dout", Dout, 64'd0);
    chk("fs_done", 64'(done), 64'd0);

    // reset mid-operation
    @(negedge clk);
    Din         = 64'h77;
    ShiftDir    = 1'b0;
    Shamt       = 6'd20;
    ShiftToALUB = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mrst_dout", Dout, 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_tag", 64'(ShiftToALUBO), 64'd0);
    repeat (25) @(negedge clk);
    chk("mrst_idle", 64'(busy), 64'd0);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_shift_unit.md
EX_SHIFT_UNIT -- requirements
Module: ex_shift_unit

Interface
REQ-001 The block SHALL have one clock domain; reset SHALL be synchronous and active-low.
REQ-002 The ports SHALL be exactly as follows:
  clk  in  1  system clock, all state updates on rising edge
  reset  in  1  synchronous active-low reset
  start  in  1  request new shift; sampled only in IDLE
  flush  in  1  synchronous abort of current operation
  ShiftDir  in  1  0 = logical left (LSL), 1 = logical right (LSR)
  ShiftToALUB  in  1  destination tag, latched at start
  Shamt  in  6  shift amount 0..63
  Din  in  64  operand
  Dout  out  64  shift result, valid while done=1
  done  out  1  one-cycle completion pulse
  busy  out  1  high whenever state != IDLE; drives pipeline stall
  ShiftToALUBO  out  1  latched ShiftToALUB of current/last operation

Function
REQ-003 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-004 In IDLE with start=1 and flush=0, the block SHALL latch Din into Dout, latch ShiftDir, ShiftToALUB, and load remaining count = Shamt.
REQ-005 From IDLE on start, next state SHALL be DONE if Shamt=0, else SHIFT.
REQ-006 In SHIFT, each edge SHALL shift Dout by step bits, zero-fill, direction per latched ShiftDir, and decrement count by step.
REQ-007 step SHALL be 1 by default (see REQ-016).
REQ-008 SHIFT SHALL transition to DONE on the edge where count becomes 0.
REQ-009 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-010 start SHALL be ignored in SHIFT and DONE; no queuing.
REQ-011 Latency: done SHALL be high in the cycle after Shamt+1 rising edges, counting the edge that samples start.
REQ-012 flush=1 SHALL force IDLE on the next edge from any state, clear Dout to 0, suppress done; flush wins over simultaneous start.
REQ-013 Dout SHALL hold its value in IDLE after DONE until the next accepted start or flush.
REQ-014 busy SHALL be combinational from state only (no input-to-output path).

Reset
REQ-015 reset=0 at an edge SHALL force IDLE, Dout=0, count=0, done=0, busy=0, ShiftToALUBO=0, overriding start and flush, including mid-operation.

Configuration
REQ-016 With macro EX_SHIFT_MULTIBIT_EN defined, step SHALL be min(count, 8), giving latency ceil(Shamt/8)+1 edges; without it, step SHALL be 1 and latency Shamt+1 edges; all other behaviour identical.

Verification
REQ-017 Reset: hold reset=0 one edge during SHIFT -> Dout=0, done=0, busy=0 next cycle.
REQ-018 Din=64'h1, ShiftDir=0, Shamt=4, start one cycle -> busy high 5 cycles, done after 5th edge, Dout=64'h10 (macro: after 2nd edge).
REQ-019 Din=64'h8000_0000_0000_0000, ShiftDir=1, Shamt=63 -> Dout=64'h1 with done after 64 edges (macro: 9 edges).
REQ-020 Din=64'hDEAD_BEEF, Shamt=0, ShiftToALUB=1 -> done after 1 edge, Dout=64'hDEAD_BEEF, ShiftToALUBO=1.
REQ-021 Shamt=10 started, flush=1 on 3rd cycle of SHIFT -> IDLE next edge, Dout=0, done never asserted; start held during SHIFT produces no second operation.
REQ-022 flush=1 and start=1 together in IDLE -> stays IDLE, busy=0, Dout=0.
